// File: rtl/longmultiplier_pkg.sv
// longmultiplier_pkg: FSM state encoding and default widths shared with the long divider.
package longmultiplier_pkg;
  typedef enum logic [1:0] {S1 = 2'b00, S2 = 2'b01, S3 = 2'b10} state_t;
  localparam int N_DEF = 8;
  localparam int LOGN_DEF = 3;
endpackage

// File: rtl/longmultiplier_shiftlne.sv
// shiftlne: left shift register with parallel load L, shift enable E and serial input w.
module shiftlne #(
  parameter int n = 16
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic [n-1:0] R,
  input  logic         L,
  input  logic         E,
  input  logic         w,
  output logic [n-1:0] Q
);
  always_ff @(posedge Clock)
    if (Reset) Q <= '0;
    else if (L) Q <= R;
    else if (E) Q <= {Q[n-2:0], w};
endmodule

// File: rtl/longmultiplier_shiftrne.sv
// shiftrne: right shift register with parallel load L, shift enable E and serial input w.
module shiftrne #(
  parameter int n = 8
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic [n-1:0] R,
  input  logic         L,
  input  logic         E,
  input  logic         w,
  output logic [n-1:0] Q
);
  always_ff @(posedge Clock)
    if (Reset) Q <= '0;
    else if (L) Q <= R;
    else if (E) Q <= {w, Q[n-1:1]};
endmodule

// File: rtl/longmultiplier.sv
// longmultiplier: shift-and-add unit computing P = A*B + C in n cycles with start/Done handshake.
module longmultiplier
  import longmultiplier_pkg::*;
#(
  parameter int n    = N_DEF,
  parameter int logn = LOGN_DEF
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           s,
  input  logic           LA,
  input  logic           EB,
  input  logic [n-1:0]   DataA,
  input  logic [n-1:0]   DataB,
  input  logic [n-1:0]   DataC,
  output logic [2*n-1:0] P,
  output logic           Done
);
  state_t state_q, state_d;
  logic [n-1:0] a, b_q;
  logic [2*n-1:0] bx, p_q, p_d;
  logic [logn-1:0] cnt_q, cnt_d;
  logic idle, run;
  assign idle = state_q == S1;
  assign run  = state_q == S2;
  assign Done = state_q == S3;
  assign P    = p_q;
  always_comb begin
    state_d = S1;
    case (state_q)
      S1:      state_d = s ? S2 : S1;
      S2:      state_d = (cnt_q == '0) ? S3 : S2;
      S3:      state_d = s ? S3 : S1;
      default: state_d = S1;
    endcase
    cnt_d = idle ? logn'(n - 1) : run ? cnt_q - 1'b1 : cnt_q;
    p_d   = idle ? {{n{1'b0}}, DataC} : (run && a[0]) ? p_q + bx : p_q;
  end
  always_ff @(posedge Clock)
    if (Reset) begin
      state_q <= S1;
      p_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      if (idle && EB) b_q <= DataB;
    end
  shiftrne #(.n(n)) u_a (
    .Clock(Clock), .Reset(Reset), .R(DataA), .L(idle & LA), .E(run), .w(1'b0), .Q(a)
  );
  // Bx takes DataB directly when EB coincides with the start edge, so the new B is used
  shiftlne #(.n(2 * n)) u_bx (
    .Clock(Clock), .Reset(Reset), .R({{n{1'b0}}, EB ? DataB : b_q}), .L(idle), .E(run),
    .w(1'b0), .Q(bx)
  );
endmodule

// File: doc/longmultiplier.md
Name: longmultiplier

Overview:
- Sequential shift-and-add multiply-accumulate unit that computes P = A*B + C on unsigned n-bit operands.
- It is the inverse companion of the long divider. Feeding it quotient, divisor and remainder (A=Q, B=divisor, C=R) reconstructs the dividend.
- It is used as a divider self-check and as a general multiplier in the same datapath family.
- It uses the same start/Done handshake and load-enable operand style as the divider. It takes a fixed n compute cycles per operation.

Parameters:
- n, 8, operand width in bits; the product is 2n bits.
- logn, 3, counter width; must equal ceil(log2(n)).

Ports:
- Clock  in  1  system clock, rising-edge.
- Reset  in  1  synchronous, active-high reset.
- s  in  1  start / hold request (level).
- LA  in  1  load DataA into the multiplier register A.
- EB  in  1  load DataB into the multiplicand register B.
- DataA  in  n  multiplier operand.
- DataB  in  n  multiplicand operand.
- DataC  in  n  addend; zero-extended into P.
- P  out  2n  product/accumulator register.
- Done  out  1  result valid (level).

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports Clock, Reset).
- Reset (sampled at the rising edge) takes priority over everything:
  - state <= S1, P <= 0, A <= 0, B <= 0, Count <= 0.
  - Done = 0 from that edge onward.
  - Reset asserted mid-operation aborts the operation; no partial result survives.
- State S1 (idle/load):
  - P <= {n'b0, DataC} every cycle.
  - Count <= n-1.
  - LA loads A, EB loads B.
  - s=1 moves to S2 on that edge. The operands loaded on that same edge are the ones used.
- State S2 (compute), one step per cycle:
  - If A[0]=1 then P <= P + Bx, where Bx is the 2n-bit multiplicand register; otherwise P is held.
  - A shifts right with 0 shifted in.
  - Bx shifts left with 0 shifted in.
  - Count decrements.
  - When Count==0 at an edge, that edge performs the final step and moves to S3.
  - S2 lasts exactly n cycles regardless of operand values; there is no early exit.
- Bx handling: Bx <= {n'b0, B} on every S1 cycle. B itself is unchanged during compute.
- State S3 (done):
  - Done=1 combinationally from state.
  - P, A and B are held.
  - s=0 moves to S1; s=1 stays in S3.
- Encoding: 2-bit state; the unused encoding goes to S1 on the next edge.
- Latency: s sampled high in S1 at edge t0 gives Done=1 after edge t0+n. P is final at that same point.
- Arithmetic:
  - 2n-bit unsigned addition.
  - Maximum result (2^n-1)^2 + (2^n-1) = 2^n(2^n-1) < 2^2n, so there is no overflow and no carry-out port.
- Operand loads:
  - LA and EB are honoured only in S1; they are ignored in S2 and S3.
  - LA, EB and s all high on the same S1 edge: the loads take effect and compute starts next cycle with the new values.
  - DataC must be valid at the edge that samples s.
- Outputs during S2: P shows the partial sum and is not meaningful until Done.
- Back-to-back operations need at least one S1 cycle. That S1 cycle reloads P from DataC.

Decomposition:
- Shared package:
  - State constants S1=2'b00, S2=2'b01, S3=2'b10.
  - Default n/logn values, shared with the divider so both blocks agree on width.
- Structure: FSM (state table, state flops, outputs) plus the datapath in the top module.
- Sub-modules:
  - One natural sub-module, shiftrne: right shift register with parallel load L, enable E, serial input w. Used for A.
  - Bx uses a left-shift 2n-bit instance of the existing left-shift-with-load register.
- Reset behaviour: all new registers take synchronous active-high Reset.

Test Plan:
- Basic multiply-accumulate: LA/EB with A=13, B=11, DataC=7, then s=1 → Done rises exactly 8 cycles after the s edge, P=150.
- Maximum operands: A=255, B=255, C=255 → P=65280. No wrap occurs, and the upper product bits are exercised.
- Zero and identity operands:
  - A=0, B=200, C=0 → P=0 after 8 cycles; latency is unchanged.
  - A=1, B=0, C=99 → P=99.
- Divider inverse: A=Q=19, B=12, C=R=7 → P=235. Also a random loop of 1000 divider outputs must each reconstruct its dividend.
- Reset mid-compute: Reset=1 on the 4th S2 cycle → at the next edge P=0, Done=0 and state S1. A fresh run with A=6, B=7, C=1 gives P=43.
- Hold and protection:
  - Keep s=1 after Done → Done stays 1 and P is stable for 5 cycles.
  - Pulse LA with DataA=3 and EB with DataB=9 while in S3 and S2 → ignored, P unchanged.
  - Drop s → S1 next edge, Done=0.
